// File: rtl/nn_pkg.sv
// Shared definitions for the neuron-layer datapath: default word width,
// activation ceiling, writer state encoding and packed-bus lane helpers.
package nn_pkg;

    // Default accumulator / bias / activation width (two's complement).
    localparam int DATA_W_DEFAULT = 8;

    // Largest activation value at the default width.
    localparam int ACT_MAX = 2 ** (DATA_W_DEFAULT - 1) - 1;

    // Writer sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lowest bit index of lane 'lane' in a packed bus of 'width'-bit words.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    // Largest non-negative value representable in a 'width'-bit signed word.
    function automatic int act_max(input int width);
        return (2 ** (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/nn_relu_sat.sv
// Bias add, ReLU and positive saturation for one neuron lane.
// Purely combinational so later layers can reuse it unchanged.
module nn_relu_sat
    import nn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] bias,
    output logic [DATA_W-1:0] act
);

    // Positive ceiling: sign bit clear, all magnitude bits set.
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};

    // One extra bit so the sum of two sign-extended words cannot overflow.
    logic [DATA_W:0] sum;

    // Sign-extended add, then clamp into 0..SAT_MAX.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        act = '0;
        sum = {acc[DATA_W-1], acc} + {bias[DATA_W-1], bias};
        if (sum[DATA_W]) begin
            // Negative sum: ReLU clamps to zero.
            act = '0;
        end else if (sum[DATA_W-1]) begin
            // Non-negative but beyond the signed word range.
            act = SAT_MAX;
        end else begin
            act = sum[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_activation_writer.sv
// Captures all neuron accumulators on the upstream ack, streams one
// activation per cycle into the next layer's input memory, then pulses
// req_next. A single shared relu/saturate unit is time-multiplexed over
// the lanes by the lane counter.
module neuron_activation_writer
    import nn_pkg::*;
#(
    parameter int N_NEURONS = 2,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int ADDR_W    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ack_in,
    input  logic [N_NEURONS*DATA_W-1:0]   acc_in,
    input  logic [N_NEURONS*DATA_W-1:0]   bias_in,
    output logic                          mem_trig_w,
    output logic [ADDR_W-1:0]             mem_abus_w,
    output logic [DATA_W-1:0]             mem_dbus_w,
    output logic                          req_next,
    output logic                          busy,
    output logic                          overrun
);

    localparam logic [ADDR_W-1:0] LAST_LANE = ADDR_W'(N_NEURONS - 1);

    state_t                        state;
    state_t                        state_nxt;
    logic [ADDR_W-1:0]             lane;
    logic [N_NEURONS*DATA_W-1:0]   acc_q;
    logic [N_NEURONS*DATA_W-1:0]   bias_q;
    logic [DATA_W-1:0]             sel_acc;
    logic [DATA_W-1:0]             sel_bias;
    logic [DATA_W-1:0]             lane_act;
    logic                          accept;

    // A new burst starts only from IDLE; acks seen elsewhere are overruns.
    assign accept = (state == IDLE) && ack_in;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> EMIT on ack, EMIT for N lanes, one DONE cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (ack_in) state_nxt = EMIT;
            EMIT:    if (lane == LAST_LANE) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture registers and lane counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the capture bank is a handful of flops, not a RAM, so it
            // is cleared on reset; a real memory array would be left unreset.
            acc_q  <= '0;
            bias_q <= '0;
            lane   <= '0;
        end else if (accept) begin
            acc_q  <= acc_in;
            bias_q <= bias_in;
            lane   <= '0;
        end else if ((state == EMIT) && (lane != LAST_LANE)) begin
            // Hold on the last lane so the address never wraps mid-burst.
            lane <= lane + 1'b1;
        end
    end

    // Sticky overrun: any ack while a burst is in flight; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ack_in && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Lane mux feeding the shared activation unit.
    always_comb begin
        sel_acc  = '0;
        sel_bias = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (lane == ADDR_W'(i)) begin
                sel_acc  = acc_q[lane_lo(i, DATA_W) +: DATA_W];
                sel_bias = bias_q[lane_lo(i, DATA_W) +: DATA_W];
            end
        end
    end

    nn_relu_sat #(
        .DATA_W (DATA_W)
    ) u_relu_sat (
        .acc  (sel_acc),
        .bias (sel_bias),
        .act  (lane_act)
    );

    // Write port and handshake outputs decoded from registered state only,
    // so address and data are stable for the whole strobe cycle.
    always_comb begin
        mem_trig_w = (state == EMIT);
        mem_abus_w = '0;
        mem_dbus_w = '0;
        if (state == EMIT) begin
            mem_abus_w = lane;
            mem_dbus_w = lane_act;
        end
        req_next = (state == DONE);
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_neuron_activation_writer.sv
// Randomized self-checking bench for neuron_activation_writer. A
// cycle-indexed schedule of expected write-port activity is built from the
// behavioural rules (burst of N writes, one req, busy window, overrun).
module tb_neuron_activation_writer;

    localparam int N    = 2;
    localparam int W    = 8;
    localparam int A    = 1;
    localparam int MAXC = 8192;

    logic             clk = 1'b0;
    logic             rst;
    logic             ack_in;
    logic [N*W-1:0]   acc_in;
    logic [N*W-1:0]   bias_in;
    logic             mem_trig_w;
    logic [A-1:0]     mem_abus_w;
    logic [W-1:0]     mem_dbus_w;
    logic             req_next;
    logic             busy;
    logic             overrun;

    neuron_activation_writer #(
        .N_NEURONS (N),
        .DATA_W    (W),
        .ADDR_W    (A)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ack_in     (ack_in),
        .acc_in     (acc_in),
        .bias_in    (bias_in),
        .mem_trig_w (mem_trig_w),
        .mem_abus_w (mem_abus_w),
        .mem_dbus_w (mem_dbus_w),
        .req_next   (req_next),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected activity for the cycle following edge index k.
    bit e_trig [MAXC];
    int e_addr [MAXC];
    int e_data [MAXC];
    bit e_req  [MAXC];
    bit e_busy [MAXC];
    bit e_ovr;
    int next_ok;
    int edge_idx;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        if (obs !== 32'(exp)) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_idx, obs, exp);
        end
    endtask

    // Reference activation: plain integer sum, then clamp to 0..2**(W-1)-1.
    function automatic int ref_act(input int a, input int b);
        int s;
        s = a + b;
        if (s < 0) return 0;
        if (s > (2 ** (W - 1)) - 1) return (2 ** (W - 1)) - 1;
        return s;
    endfunction

    function automatic int lane_val(input logic [N*W-1:0] bus, input int i);
        logic signed [W-1:0] v;
        v = bus[i*W +: W];
        return int'(v);
    endfunction

    // Apply the behavioural rules for the edge about to be sampled.
    task automatic model_edge(input bit r, input bit a,
                              input logic [N*W-1:0] ac, input logic [N*W-1:0] bc);
        int t;
        t = edge_idx;
        if (r) begin
            for (int k = t; k <= t + N + 2; k++) begin
                e_trig[k] = 1'b0;
                e_req[k]  = 1'b0;
                e_busy[k] = 1'b0;
            end
            e_ovr   = 1'b0;
            next_ok = t + 1;
        end else if (a) begin
            if (t >= next_ok) begin
                for (int k = 0; k < N; k++) begin
                    e_trig[t + k] = 1'b1;
                    e_addr[t + k] = k;
                    e_data[t + k] = ref_act(lane_val(ac, k), lane_val(bc, k));
                end
                for (int k = 0; k <= N; k++) e_busy[t + k] = 1'b1;
                e_req[t + N] = 1'b1;
                next_ok      = t + N + 2;
            end else begin
                e_ovr = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs, update model at the edge, check on negedge.
    task automatic step(input bit r, input bit a,
                        input logic [N*W-1:0] ac, input logic [N*W-1:0] bc);
        rst     = r;
        ack_in  = a;
        acc_in  = ac;
        bias_in = bc;
        @(posedge clk);
        model_edge(r, a, ac, bc);
        @(negedge clk);
        check("trig", 32'(mem_trig_w), int'(e_trig[edge_idx]));
        check("req", 32'(req_next), int'(e_req[edge_idx]));
        check("busy", 32'(busy), int'(e_busy[edge_idx]));
        check("overrun", 32'(overrun), int'(e_ovr));
        if (e_trig[edge_idx]) begin
            check("addr", 32'(mem_abus_w), e_addr[edge_idx]);
            check("data", 32'(mem_dbus_w), e_data[edge_idx]);
        end
        if (r) begin
            check("rst_addr", 32'(mem_abus_w), 0);
            check("rst_data", 32'(mem_dbus_w), 0);
        end
        edge_idx++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [N*W-1:0] ac;
        logic [N*W-1:0] bc;
        e_ovr    = 1'b0;
        next_ok  = 0;
        edge_idx = 0;
        rst      = 1'b1;
        ack_in   = 1'b0;
        acc_in   = '0;
        bias_in  = '0;
        @(negedge clk);

        // Reset state.
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);
        idle(2);

        // Basic burst: acc={10,20}, bias={1,-5} -> 11, 15.
        step(1'b0, 1'b1, {8'd20, 8'd10}, {8'hFB, 8'h01});
        idle(4);

        // Saturation and ReLU: {100,-20}+{50,5} -> 127, 0.
        step(1'b0, 1'b1, {8'hEC, 8'd100}, {8'd5, 8'd50});
        idle(4);
        // Extremes: {-128,127}+{-128,127} -> 0, 127.
        step(1'b0, 1'b1, {8'h7F, 8'h80}, {8'h7F, 8'h80});
        idle(4);

        // Acks at T+1 and T+3 are ignored and set overrun.
        step(1'b0, 1'b1, {8'd3, 8'd40}, {8'd2, 8'd1});
        step(1'b0, 1'b1, {8'd99, 8'd99}, {8'd0, 8'd0});
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, {8'd77, 8'd66}, {8'd0, 8'd0});
        idle(5);
        step(1'b1, 1'b0, '0, '0);

        // Back-to-back: next ack exactly at T+N+2 is accepted.
        step(1'b0, 1'b1, {8'd5, 8'd6}, {8'd7, 8'd8});
        idle(3);
        step(1'b0, 1'b1, {8'hF0, 8'd60}, {8'd30, 8'd70});
        idle(4);

        // Reset during the first EMIT cycle aborts the burst.
        step(1'b0, 1'b1, {8'd9, 8'd9}, {8'd1, 8'd1});
        step(1'b1, 1'b0, '0, '0);
        idle(4);

        // Reset and ack together: nothing captured; a later ack works.
        step(1'b1, 1'b1, {8'd50, 8'd50}, {8'd0, 8'd0});
        idle(2);
        step(1'b0, 1'b1, {8'd20, 8'd10}, {8'hFB, 8'h01});
        idle(4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            ac = (N*W)'($urandom);
            bc = (N*W)'($urandom);
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 40, ac, bc);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_activation_writer.md
Name: neuron_activation_writer

Overview:
- Downstream stage of the neurons layer. Captures all N accumulator results when the layer pulses its ack.
- Applies per-neuron bias add, ReLU and positive saturation to each result.
- Writes the activations one per cycle into the next layer's input memory through a trig/abus/dbus write port.
- Pulses a req to start the next layer once the last activation is written.

Parameters:
- N_NEURONS, 2, number of neurons (accumulator lanes) in the upstream layer.
- DATA_W, 8, width of accumulator, bias and activation words (two's complement).
- ADDR_W, 1, width of the next layer's memory address; must satisfy 2**ADDR_W >= N_NEURONS.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- ack_in  input  1  one-cycle pulse from the neurons layer: acc_in is valid.
- acc_in  input  N_NEURONS*DATA_W  accumulator results, lane i at bits [i*DATA_W +: DATA_W], signed.
- bias_in  input  N_NEURONS*DATA_W  per-neuron bias, same packing, signed; sampled with acc_in.
- mem_trig_w  output  1  write strobe to the next layer's input memory.
- mem_abus_w  output  ADDR_W  write address.
- mem_dbus_w  output  DATA_W  write data.
- req_next  output  1  one-cycle pulse: all activations written, start the next layer.
- busy  output  1  high whenever the state is not IDLE.
- overrun  output  1  sticky flag: ack_in arrived while busy.

Behaviour:
- Reset values: mem_trig_w=0, mem_abus_w=0, mem_dbus_w=0, req_next=0, busy=0, overrun=0, state=IDLE, lane counter=0. Capture registers are cleared to 0.
- States: IDLE, EMIT, DONE.
  - IDLE, ack_in=1 at edge T: register acc_in and bias_in, go to EMIT, counter=0.
  - EMIT: each edge drives mem_trig_w=1, mem_abus_w=counter, mem_dbus_w=act(counter), then increments counter. After lane N_NEURONS-1, go to DONE.
  - DONE: mem_trig_w=0, req_next=1 for exactly one cycle, then return to IDLE.
- Timing for ack at edge T:
  - Writes are visible in cycles T+1..T+N_NEURONS.
  - req_next is visible in cycle T+N_NEURONS+1.
  - busy is high over T+1..T+N_NEURONS+1.
  - The earliest next accepted ack is at edge T+N_NEURONS+2.
- mem_abus_w and mem_dbus_w stay stable for the whole cycle mem_trig_w is high; the downstream memory writes on negedge.
- Activation per lane: s = sext(acc) + sext(bias) in DATA_W+1 bits, so the sum cannot overflow.
  - act = 0 if s < 0.
  - act = 2**(DATA_W-1)-1 if s > 2**(DATA_W-1)-1.
  - Otherwise act = s[DATA_W-1:0].
- Outputs always lie in 0..2**(DATA_W-1)-1.
- ack_in while busy (EMIT or DONE): ignored, captured data unchanged, overrun set to 1. overrun is cleared only by rst.
- rst mid-EMIT: at that edge mem_trig_w goes to 0 and state to IDLE. No further writes; no req_next for the aborted burst.
- rst and ack_in in the same cycle: rst wins, nothing is captured.
- Addresses never wrap within a burst. The counter restarts at 0 for every burst.

Decomposition:
- Shared package nn_pkg:
  - DATA_W default and the state enum {IDLE, EMIT, DONE}.
  - ACT_MAX = 2**(DATA_W-1)-1.
  - A lane-slice helper for packed buses.
- One sub-module: nn_relu_sat, purely combinational, (acc, bias) -> act.
  - Instantiated once, driven by a mux selected by the lane counter.
  - Reusable by later layers.

Test Plan:
- N=2: ack with acc={10,20}, bias={1,-5} -> writes addr0=11 at T+1, addr1=15 at T+2; req_next at T+3; busy high for exactly 3 cycles.
- Saturation and ReLU: acc={100,-20}, bias={50,5} -> addr0=127, addr1=0; acc={-128,127}, bias={-128,127} -> 0, 127 (no wrap).
- ack_in pulsed again at T+1 and T+3 -> second and third pulses ignored, written data unchanged, overrun=1 and held until rst.
- ack at edge T+N+2 right after DONE -> accepted, new burst starts, overrun stays 0.
- rst asserted during the first EMIT cycle -> mem_trig_w=0 next cycle, no addr1 write, no req_next, all outputs at reset values.
- rst and ack_in asserted together -> no capture, no writes; a later ack behaves as in the first scenario.
